// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// - state_t      : arbiter FSM encodings (ST_IDLE, ST_ACCESS, ST_RESP)
// - REQ_CORE/LOAD: requester ids (0 = core load/store unit, 1 = loader/debug)
// - CNT_W        : width of the optional statistics counters
// - sat_inc      : saturating increment used by the statistics counters
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    localparam int CNT_W = 16;

    // Counts up by one when en is set, sticking at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant picker, purely combinational.
// Ports:
//   req[1:0]  in   request lines (bit N = requester N valid)
//   last      in   id of the requester served most recently
//   prio_mode in   1 = fixed priority (req0 always wins), 0 = round-robin
//   gnt[1:0]  out  one-hot grant, all zero when nobody requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_mode,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            // Contention: round-robin hands the slot to whoever was not
            // served last; fixed priority always picks req0.
            2'b11: gnt = (prio_mode || last) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the core load/store unit (req0)
// and the loader/debug port (req1). One transaction at a time, three cycles
// each: IDLE (arbitrate + handshake) -> ACCESS (drive memory) -> RESP (strobe
// the response back to the requester that was accepted).
//
// Ports:
//   clk, rst                       clock (rising edge), async active-low reset
//   reqN_valid/we/addr/wdata       request from requester N
//   reqN_ready                     request accepted this cycle (valid & ready)
//   rspN_valid/rdata/err           one-cycle response to requester N
//   Mem_Write/Mem_Read/Read_addr/Write_Data  drive data_memory
//   Mem_data_out                   combinational read data from data_memory
//   busy                           FSM is not in IDLE
//   grant_cnt0/1, conflict_cnt     statistics, present only when the macro
//                                  DMEM_ARB_STATS_EN is defined
//
// Parameters: ADDR_W, DATA_W, MEM_DEPTH (addresses >= MEM_DEPTH are errors),
//             PRIO_MODE (0 = round-robin, 1 = fixed priority for req0).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 64,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              Mem_Write,
    output logic              Mem_Read,
    output logic [ADDR_W-1:0] Read_addr,
    output logic [DATA_W-1:0] Write_Data,
    input  logic [DATA_W-1:0] Mem_data_out,
    output logic              busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    localparam logic PRIO_FIXED = (PRIO_MODE != 0);

    state_t            state_reg, state_next;
    logic              id_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;
    logic              last_reg;

    logic [1:0]        req_valid;
    logic [1:0]        gnt;
    logic [1:0]        ready;
    logic              in_idle;
    logic              handshake;
    logic              in_range;

    logic              rsp_valid [2];
    logic [DATA_W-1:0] rsp_rdata [2];
    logic              rsp_err   [2];

    assign req_valid = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .req       (req_valid),
        .last      (last_reg),
        .prio_mode (PRIO_FIXED),
        .gnt       (gnt)
    );

    // ready is combinational from valid; gating with rst keeps every output
    // quiet while reset is held, even though the request inputs may toggle.
    assign in_idle   = (state_reg == ST_IDLE) && rst;
    assign ready     = gnt & {2{in_idle}};
    assign handshake = |ready;
    assign in_range  = (addr_reg < ADDR_W'(MEM_DEPTH));

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign busy       = (state_reg != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Memory strobes come straight from the state register, so an async
    // reset during ACCESS removes them in the same instant.
    always_comb begin
        state_next = state_reg;
        Mem_Write  = 1'b0;
        Mem_Read   = 1'b0;
        Read_addr  = '0;
        Write_Data = '0;
        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                Read_addr  = addr_reg;
                Write_Data = wdata_reg;
                if (in_range) begin
                    Mem_Write = we_reg;
                    Mem_Read  = !we_reg;
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request capture, response data and round-robin history. last_reg
    // resets to REQ_LOAD so the first contended grant goes to the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_reg    <= REQ_CORE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            last_reg  <= REQ_LOAD;
        end else begin
            if (handshake) begin
                id_reg    <= ready[1];
                we_reg    <= ready[1] ? req1_we    : req0_we;
                addr_reg  <= ready[1] ? req1_addr  : req0_addr;
                wdata_reg <= ready[1] ? req1_wdata : req0_wdata;
            end
            if (state_reg == ST_ACCESS) begin
                rdata_reg <= (in_range && !we_reg) ? Mem_data_out : '0;
                err_reg   <= !in_range;
            end
            if (state_reg == ST_RESP) begin
                last_reg <= id_reg;
            end
        end
    end

    // Response fields are zero except in the single RESP cycle of the
    // requester that owns the transaction.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_valid[gi] = (state_reg == ST_RESP) && (id_reg == (gi == 1));
        assign rsp_rdata[gi] = rsp_valid[gi] ? rdata_reg : '0;
        assign rsp_err[gi]   = rsp_valid[gi] && err_reg;
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp0_rdata = rsp_rdata[0];
    assign rsp0_err   = rsp_err[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp1_rdata = rsp_rdata[1];
    assign rsp1_err   = rsp_err[1];

`ifdef DMEM_ARB_STATS_EN
    for (gi = 0; gi < 2; gi++) begin : g_grant_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= sat_inc(cnt_reg, ready[gi]);
            end
        end
    end

    logic [CNT_W-1:0] conflict_reg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_reg <= '0;
        end else begin
            conflict_reg <= sat_inc(conflict_reg, in_idle && (&req_valid));
        end
    end

    assign grant_cnt0   = g_grant_cnt[0].cnt_reg;
    assign grant_cnt1   = g_grant_cnt[1].cnt_reg;
    assign conflict_cnt = conflict_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        p_valid0, p_valid1;

    logic        req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata, Read_addr, Write_Data, Mem_data_out;
    logic        Mem_Write, Mem_Read, busy;

    logic        p_req0_ready, p_req1_ready, p_rsp0_valid, p_rsp0_err, p_rsp1_valid, p_rsp1_err;
    logic [31:0] p_rsp0_rdata, p_rsp1_rdata, p_Read_addr, p_Write_Data, p_Mem_data_out;
    logic        p_Mem_Write, p_Mem_Read, p_busy;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
    logic [15:0] p_grant_cnt0, p_grant_cnt1, p_conflict_cnt;
`endif

    dmem_arbiter #(.PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .Read_addr(Read_addr),
        .Write_Data(Write_Data), .Mem_data_out(Mem_data_out), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
    );

    dmem_arbiter #(.PRIO_MODE(1)) dut_p (
        .clk(clk), .rst(rst),
        .req0_valid(p_valid0), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(p_req0_ready),
        .req1_valid(p_valid1), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(p_req1_ready),
        .rsp0_valid(p_rsp0_valid), .rsp0_rdata(p_rsp0_rdata), .rsp0_err(p_rsp0_err),
        .rsp1_valid(p_rsp1_valid), .rsp1_rdata(p_rsp1_rdata), .rsp1_err(p_rsp1_err),
        .Mem_Write(p_Mem_Write), .Mem_Read(p_Mem_Read), .Read_addr(p_Read_addr),
        .Write_Data(p_Write_Data), .Mem_data_out(p_Mem_data_out), .busy(p_busy)
`ifdef DMEM_ARB_STATS_EN
        , .grant_cnt0(p_grant_cnt0), .grant_cnt1(p_grant_cnt1), .conflict_cnt(p_conflict_cnt)
`endif
    );

    // data_memory models: combinational read, write on rising edge
    logic [31:0] mem  [64];
    logic [31:0] pmem [64];
    logic        mem_load;

    always_comb Mem_data_out   = (Read_addr   < 64) ? mem[Read_addr[5:0]]    : 32'd0;
    always_comb p_Mem_data_out = (p_Read_addr < 64) ? pmem[p_Read_addr[5:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) begin
                mem[i]  <= 32'd0;
                pmem[i] <= 32'd0;
            end
            mem[15]  <= 32'd65;
            mem[17]  <= 32'd56;
            pmem[15] <= 32'd65;
            pmem[17] <= 32'd56;
        end else begin
            if (Mem_Write && Read_addr < 64)     mem[Read_addr[5:0]]    <= Write_Data;
            if (p_Mem_Write && p_Read_addr < 64) pmem[p_Read_addr[5:0]] <= p_Write_Data;
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    // {rsp1_valid, rsp0_valid, rsp0_rdata, rsp0_err, rsp1_rdata, rsp1_err}
    function automatic logic [67:0] exp_rsp(input exp_t x);
        if (x.id) return {1'b1, 1'b0, 32'd0, 1'b0, x.rdata, x.err};
        else      return {1'b0, 1'b1, x.rdata, x.err, 32'd0, 1'b0};
    endfunction

    function automatic logic [67:0] act_rsp();
        return {rsp1_valid, rsp0_valid, rsp0_rdata, rsp0_err, rsp1_rdata, rsp1_err};
    endfunction

    function automatic logic [67:0] act_rsp_p();
        return {p_rsp1_valid, p_rsp0_valid, p_rsp0_rdata, p_rsp0_err, p_rsp1_rdata, p_rsp1_err};
    endfunction

    function automatic logic [136:0] all_outs();
        return {req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid,
                rsp1_rdata, rsp1_err, Mem_Write, Mem_Read, Read_addr, Write_Data, busy};
    endfunction

    // Drives one request on dut and waits (bounded) for its handshake.
    // Returns at the falling edge inside the ACCESS cycle.
    task automatic drive_req(input bit id, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, output bit ok);
        ok = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; p_valid0 = 1'b0; p_valid1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req0_valid = 1'($urandom); req0_we = 1'($urandom);
            req0_addr = $urandom_range(0, 70); req0_wdata = $urandom;
            req1_valid = 1'($urandom); req1_we = 1'($urandom);
            req1_addr = $urandom_range(0, 70); req1_wdata = $urandom;
            p_valid0 = 1'($urandom); p_valid1 = 1'($urandom);
            #1;
            checks++;
            if (all_outs() !== '0 || {p_req0_ready, p_req1_ready, p_busy, p_Mem_Read, p_Mem_Write} !== 5'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d got=%h required=0", k, all_outs());
            end
        end
`ifdef DMEM_ARB_STATS_EN
        checks++;
        if ({grant_cnt0, grant_cnt1, conflict_cnt} !== 48'd0) begin
            failures++;
            $display("FAIL reset_counters got=%h required=0", {grant_cnt0, grant_cnt1, conflict_cnt});
        end
`endif
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; p_valid0 = 1'b0; p_valid1 = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, rsp0_valid, rsp1_valid, Mem_Read, Mem_Write} !== 5'd0) begin
                failures++;
                $display("FAIL reset_release cycle %0d got=%b required=00000", k,
                         {busy, rsp0_valid, rsp1_valid, Mem_Read, Mem_Write});
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        bit ok;
        drive_req(1'b0, 1'b1, 32'd10, 32'd100, ok);
        checks++;
        if ({ok, Mem_Write, Mem_Read, Read_addr, Write_Data} !== {1'b1, 1'b1, 1'b0, 32'd10, 32'd100}) begin
            failures++;
            $display("FAIL wr_access got ok=%b we=%b re=%b addr=%0d data=%0d required 1 1 0 10 100",
                     ok, Mem_Write, Mem_Read, Read_addr, Write_Data);
        end
        sb.push_back('{id: 1'b0, rdata: 32'd0, err: 1'b0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (act_rsp() !== exp_rsp(e) || {Mem_Write, Mem_Read} !== 2'b00) begin
            failures++;
            $display("FAIL wr_rsp got=%h strobes=%b required=%h strobes=00", act_rsp(), {Mem_Write, Mem_Read}, exp_rsp(e));
        end
        @(negedge clk);
        drive_req(1'b0, 1'b0, 32'd10, 32'd0, ok);
        checks++;
        if ({ok, Mem_Write, Mem_Read, Read_addr} !== {1'b1, 1'b0, 1'b1, 32'd10}) begin
            failures++;
            $display("FAIL rd_access got ok=%b we=%b re=%b addr=%0d required 1 0 1 10",
                     ok, Mem_Write, Mem_Read, Read_addr);
        end
        sb.push_back('{id: 1'b0, rdata: 32'd100, err: 1'b0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (act_rsp() !== exp_rsp(e)) begin
            failures++;
            $display("FAIL rd_rsp got=%h required=%h", act_rsp(), exp_rsp(e));
        end
        @(negedge clk);
        $display("test_write_read done");
    endtask

    task automatic test_both_valid();
        pulse_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd15;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'd17;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL both_first_grant got=%b required=01", {req1_ready, req0_ready});
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        sb.push_back('{id: 1'b0, rdata: 32'd65, err: 1'b0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (act_rsp() !== exp_rsp(e) || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL both_rsp0 got=%h ready1=%b required=%h ready1=0", act_rsp(), req1_ready, exp_rsp(e));
        end
        @(negedge clk);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            failures++;
            $display("FAIL both_second_grant got=%b required=10", {req1_ready, req0_ready});
        end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        sb.push_back('{id: 1'b1, rdata: 32'd56, err: 1'b0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (act_rsp() !== exp_rsp(e)) begin
            failures++;
            $display("FAIL both_rsp1 got=%h required=%h", act_rsp(), exp_rsp(e));
        end
        @(negedge clk);
        $display("test_both_valid done");
    endtask

    task automatic test_round_robin();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd15;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'd17;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] want;
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== want) begin
                failures++;
                $display("FAIL rr_grant %0d got=%b required=%b", k, {req1_ready, req0_ready}, want);
            end
            sb.push_back('{id: want[1], rdata: (want[1] ? 32'd56 : 32'd65), err: 1'b0});
            @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (act_rsp() !== exp_rsp(e)) begin
                failures++;
                $display("FAIL rr_rsp %0d got=%h required=%h", k, act_rsp(), exp_rsp(e));
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        $display("test_round_robin done");
    endtask

    task automatic test_fixed_prio();
        req0_we = 1'b0; req0_addr = 32'd15;
        req1_we = 1'b0; req1_addr = 32'd17;
        p_valid0 = 1'b1; p_valid1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] want;
            if (k == 3) p_valid0 = 1'b0;
            want = (k == 3) ? 2'b10 : 2'b01;
            #1;
            checks++;
            if ({p_req1_ready, p_req0_ready} !== want) begin
                failures++;
                $display("FAIL prio_grant %0d got=%b required=%b", k, {p_req1_ready, p_req0_ready}, want);
            end
            sb.push_back('{id: want[1], rdata: (want[1] ? 32'd56 : 32'd65), err: 1'b0});
            @(posedge clk);
            @(negedge clk);
            if (k == 3) p_valid1 = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (act_rsp_p() !== exp_rsp(e)) begin
                failures++;
                $display("FAIL prio_rsp %0d got=%h required=%h", k, act_rsp_p(), exp_rsp(e));
            end
            @(negedge clk);
        end
        $display("test_fixed_prio done");
    endtask

    task automatic test_out_of_range();
        bit ok;
        drive_req(1'b1, 1'b0, 32'd64, 32'd0, ok);
        checks++;
        if ({ok, Mem_Read, Mem_Write} !== 3'b100) begin
            failures++;
            $display("FAIL oor_access got ok=%b re=%b we=%b required 1 0 0", ok, Mem_Read, Mem_Write);
        end
        sb.push_back('{id: 1'b1, rdata: 32'd0, err: 1'b1});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (act_rsp() !== exp_rsp(e)) begin
            failures++;
            $display("FAIL oor_rsp got=%h required=%h", act_rsp(), exp_rsp(e));
        end
        @(negedge clk);
        $display("test_out_of_range done");
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit saw_rsp;
        drive_req(1'b0, 1'b1, 32'd20, 32'hDEAD, ok);
        checks++;
        if ({ok, Mem_Write} !== 2'b11) begin
            failures++;
            $display("FAIL mid_pre got ok=%b we=%b required 1 1", ok, Mem_Write);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({Mem_Write, Mem_Read, busy} !== 3'b000) begin
            failures++;
            $display("FAIL mid_drop got=%b required=000", {Mem_Write, Mem_Read, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        saw_rsp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) saw_rsp = 1'b1;
        end
        checks++;
        if (saw_rsp !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_rsp got=%b required=0", saw_rsp);
        end
        drive_req(1'b0, 1'b0, 32'd20, 32'd0, ok);
        sb.push_back('{id: 1'b0, rdata: 32'd0, err: 1'b0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({ok, act_rsp()} !== {1'b1, exp_rsp(e)}) begin
            failures++;
            $display("FAIL mid_readback got ok=%b rsp=%h required 1 %h", ok, act_rsp(), exp_rsp(e));
        end
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        bit ok, all_ok;
        pulse_reset();
        @(negedge clk);
        all_ok = 1'b1;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'd15;
        drive_req(1'b0, 1'b0, 32'd15, 32'd0, ok); all_ok &= ok;
        drive_req(1'b1, 1'b0, 32'd15, 32'd0, ok); all_ok &= ok;
        drive_req(1'b0, 1'b0, 32'd17, 32'd0, ok); all_ok &= ok;
        drive_req(1'b0, 1'b0, 32'd17, 32'd0, ok); all_ok &= ok;
        drive_req(1'b1, 1'b0, 32'd17, 32'd0, ok); all_ok &= ok;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({all_ok, grant_cnt0, grant_cnt1, conflict_cnt} !== {1'b1, 16'd3, 16'd2, 16'd1}) begin
            failures++;
            $display("FAIL stats got ok=%b g0=%0d g1=%0d c=%0d required 1 3 2 1",
                     all_ok, grant_cnt0, grant_cnt1, conflict_cnt);
        end
        $display("test_stats done");
    endtask
`endif

    initial begin
        rst = 1'b0;
        mem_load = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        p_valid0 = 1'b0; p_valid1 = 1'b0;
        @(posedge clk);
        #1;
        mem_load = 1'b0;
        test_reset();
        test_write_read();
        test_both_valid();
        test_round_robin();
        test_fixed_prio();
        test_out_of_range();
        test_reset_mid();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d entries required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
